// File: rtl/ahb_def_mst_slv.sv
// AHB-Lite default master (constant IDLE driver) and default slave
// (OKAY for IDLE/BUSY, two-cycle ERROR for NONSEQ/SEQ).
module ahb_def_mst_slv #(
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned SPLIT_W   = 16,
    parameter logic [3:0]  DEF_HPROT = 4'b0001,
    parameter logic [2:0]  DEF_HSIZE = 3'b010
) (
    input  logic               HCLK,
    input  logic               HRST,
    output logic               M_HLOCK,
    output logic [ADDR_W-1:0]  M_HADDR,
    output logic [2:0]         M_HSIZE,
    output logic               M_HWRITE,
    output logic [1:0]         M_HTRANS,
    output logic [2:0]         M_HBURST,
    output logic [3:0]         M_HPROT,
    output logic [DATA_W-1:0]  M_HWDATA,
    input  logic [1:0]         HTRANS,
    input  logic               HREADY,
    input  logic               DefaultSlv,
    output logic               HREADY_O,
    output logic [1:0]         HRESP,
    output logic [DATA_W-1:0]  HRDATA,
    output logic [SPLIT_W-1:0] HSPLIT
);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_ERR1 = 2'b01,
        S_ERR2 = 2'b10
    } state_t;

    localparam logic [1:0] RESP_OKAY  = 2'b00;
    localparam logic [1:0] RESP_ERROR = 2'b01;

    state_t state;
    logic   active_trans;
    logic   err_req;

    assign M_HLOCK  = 1'b0;
    assign M_HADDR  = '0;
    assign M_HSIZE  = DEF_HSIZE;
    assign M_HWRITE = 1'b0;
    assign M_HTRANS = 2'b00;
    assign M_HBURST = 3'b000;
    assign M_HPROT  = DEF_HPROT;
    assign M_HWDATA = '0;

    assign HRDATA = '0;
    assign HSPLIT = '0;

    // NONSEQ or SEQ; only accepted address phases (HREADY high) count
    assign active_trans = (HTRANS == 2'b10) || (HTRANS == 2'b11);
    assign err_req      = HREADY & DefaultSlv & active_trans;

    always_ff @(posedge HCLK or posedge HRST) begin
        if (HRST) begin
            state    <= S_IDLE;
            HREADY_O <= 1'b1;
            HRESP    <= RESP_OKAY;
        end else begin
            case (state)
                S_IDLE: begin
                    if (err_req) begin
                        state    <= S_ERR1;
                        HREADY_O <= 1'b0;
                        HRESP    <= RESP_ERROR;
                    end
                end
                S_ERR1: begin
                    state    <= S_ERR2;
                    HREADY_O <= 1'b1;
                    HRESP    <= RESP_ERROR;
                end
                S_ERR2: begin
                    if (err_req) begin
                        state    <= S_ERR1;
                        HREADY_O <= 1'b0;
                        HRESP    <= RESP_ERROR;
                    end else begin
                        state    <= S_IDLE;
                        HREADY_O <= 1'b1;
                        HRESP    <= RESP_OKAY;
                    end
                end
                default: begin
                    state    <= S_IDLE;
                    HREADY_O <= 1'b1;
                    HRESP    <= RESP_OKAY;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ahb_def_mst_slv.sv
// Scoreboard bench for ahb_def_mst_slv: a countdown model predicts
// the slave response, a negedge monitor compares against the DUT.
module tb_ahb_def_mst_slv;

    logic        HCLK = 1'b0;
    logic        HRST = 1'b1;
    logic        M_HLOCK;
    logic [31:0] M_HADDR;
    logic [2:0]  M_HSIZE;
    logic        M_HWRITE;
    logic [1:0]  M_HTRANS;
    logic [2:0]  M_HBURST;
    logic [3:0]  M_HPROT;
    logic [31:0] M_HWDATA;
    logic [1:0]  HTRANS = 2'b00;
    logic        HREADY = 1'b1;
    logic        DefaultSlv = 1'b0;
    logic        HREADY_O;
    logic [1:0]  HRESP;
    logic [31:0] HRDATA;
    logic [15:0] HSPLIT;

    ahb_def_mst_slv dut (
        .HCLK(HCLK), .HRST(HRST),
        .M_HLOCK(M_HLOCK), .M_HADDR(M_HADDR), .M_HSIZE(M_HSIZE),
        .M_HWRITE(M_HWRITE), .M_HTRANS(M_HTRANS), .M_HBURST(M_HBURST),
        .M_HPROT(M_HPROT), .M_HWDATA(M_HWDATA),
        .HTRANS(HTRANS), .HREADY(HREADY), .DefaultSlv(DefaultSlv),
        .HREADY_O(HREADY_O), .HRESP(HRESP), .HRDATA(HRDATA), .HSPLIT(HSPLIT)
    );

    always #5 HCLK = ~HCLK;

    int total = 0;
    int passed = 0;

    // Expected {HREADY_O, HRESP} for each upcoming data-phase cycle
    logic [2:0] sb[$];
    // Error cycles still owed: 2 = wait cycle, 1 = completion, 0 = none
    int err_left = 0;
    int ecount = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t",
                      name, act, exp, $time);
    endtask

    function automatic logic [2:0] expect_out(input int left);
        if (left == 2) return 3'b0_01;
        if (left == 1) return 3'b1_01;
        return 3'b1_00;
    endfunction

    task automatic consts();
        chk("m_haddr", M_HADDR, 32'h0);
        chk("m_hsize", {29'b0, M_HSIZE}, 32'h2);
        chk("m_hprot", {28'b0, M_HPROT}, 32'h1);
        chk("m_misc", {26'b0, M_HLOCK, M_HWRITE, M_HTRANS, M_HBURST[1:0]},
            32'h0);
        chk("m_hburst2", {31'b0, M_HBURST[2]}, 32'h0);
        chk("m_hwdata", M_HWDATA, 32'h0);
        chk("hrdata", HRDATA, 32'h0);
        chk("hsplit", {16'b0, HSPLIT}, 32'h0);
    endtask

    // Drive one address phase and advance the reference model at the edge
    task automatic cyc(input logic [1:0] tr, input logic rdy, input logic ds);
        HTRANS = tr;
        HREADY = rdy;
        DefaultSlv = ds;
        @(posedge HCLK);
        if (HRST) err_left = 0;
        else if (err_left == 2) err_left = 1;
        else if (rdy && ds && tr[1]) err_left = 2;
        else err_left = 0;
        if (err_left != 0) ecount++;
        sb.push_back(expect_out(err_left));
        #2;
    endtask

    always @(negedge HCLK) begin
        if (sb.size() > 0) begin
            logic [2:0] e;
            e = sb.pop_front();
            chk("slv_resp", {29'b0, HREADY_O, HRESP}, {29'b0, e});
            if (($urandom & 7) == 0) consts();
        end
    end

    initial begin
        int n_err_before;
        repeat (3) @(posedge HCLK);
        #2;
        chk("rst_hready_o", {31'b0, HREADY_O}, 32'h1);
        chk("rst_hresp", {30'b0, HRESP}, 32'h0);
        consts();
        HTRANS = 2'b10;
        DefaultSlv = 1'b1;
        @(posedge HCLK);
        #2;
        chk("rst_hold_hready_o", {31'b0, HREADY_O}, 32'h1);
        chk("rst_hold_hresp", {30'b0, HRESP}, 32'h0);
        HRST = 1'b0;
        HTRANS = 2'b00;
        DefaultSlv = 1'b0;

        cyc(2'b10, 1, 1);
        cyc(2'b00, 1, 0);
        cyc(2'b00, 1, 0);
        cyc(2'b00, 1, 0);
        cyc(2'b00, 1, 1);
        cyc(2'b01, 1, 1);
        cyc(2'b11, 1, 1);
        cyc(2'b00, 0, 0);
        cyc(2'b11, 1, 1);
        cyc(2'b00, 0, 0);
        cyc(2'b00, 1, 0);
        cyc(2'b00, 1, 0);
        cyc(2'b10, 1, 0);
        cyc(2'b10, 0, 1);
        cyc(2'b11, 0, 1);
        cyc(2'b00, 1, 0);

        for (int i = 0; i < 400; i++) begin
            logic [1:0] tr;
            tr = 2'($urandom);
            cyc(tr, ($urandom_range(0, 3) != 0), ($urandom_range(0, 1) == 1));
        end
        cyc(2'b00, 1, 0);
        cyc(2'b00, 1, 0);
        cyc(2'b00, 1, 0);

        n_err_before = ecount;
        cyc(2'b10, 1, 1);
        chk("err1_reached", {31'b0, HREADY_O}, 32'h0);
        chk("model_err_seen", 32'(ecount - n_err_before), 32'h1);
        HRST = 1'b1;
        #1;
        chk("async_rst_hready_o", {31'b0, HREADY_O}, 32'h1);
        chk("async_rst_hresp", {30'b0, HRESP}, 32'h0);
        sb.delete();
        err_left = 0;
        @(posedge HCLK);
        #1;
        chk("rst_still_idle", {29'b0, HREADY_O, HRESP}, 32'h4);
        HRST = 1'b0;
        #1;
        cyc(2'b11, 1, 1);
        cyc(2'b00, 1, 0);
        cyc(2'b00, 1, 0);
        cyc(2'b00, 1, 0);
        @(posedge HCLK);
        #2;
        @(negedge HCLK);
        #1;
        chk("sb_drained", sb.size(), 32'h0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
